// File: rtl/wb_slave_mux_pkg.sv
// Shared types and constants for the wb_slave_mux Wishbone slave fabric.
package wb_slave_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of the decoded slave index and of last_to_idx (up to 8 slaves).
  localparam int unsigned IDX_W = 3;

  localparam logic [31:0] MISS_DATA    = 32'hBADA_DD00;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // CSR window byte offsets.
  localparam int unsigned CSR_STATUS     = 32'h00;
  localparam int unsigned CSR_STATS_CLR  = 32'h0C;
  localparam int unsigned CSR_STATS_BASE = 32'h10;

endpackage

// File: rtl/wb_slave_mux_decode.sv
// Combinational address decoder: splits the aligned user area into 16
// equal windows; windows 0..NUM_SLAVES-1 are slaves, window NUM_SLAVES is
// the local CSR block, everything else is a miss.
module wb_slave_mux_decode
  import wb_slave_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int unsigned WIN_BITS   = 16
) (
  input  logic [31:0]      adr_i,
  output logic             hit_o,
  output logic             csr_hit_o,
  output logic [IDX_W-1:0] idx_o
);

  logic       region;
  logic [3:0] win;
  logic       unused_low;

  // Window offset bits are irrelevant to the decode.
  assign unused_low = ^adr_i[WIN_BITS-1:0];

  // Region match plus window number compare.
  always_comb begin
    region    = (adr_i[31:WIN_BITS+4] == ADDR_BASE[31:WIN_BITS+4]);
    win       = adr_i[WIN_BITS+3:WIN_BITS];
    hit_o     = region && (win < 4'(NUM_SLAVES));
    csr_hit_o = region && (win == 4'(NUM_SLAVES));
    idx_o     = win[IDX_W-1:0];
  end

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone slave-side fabric: forwards one upstream transaction at a time to
// one of NUM_SLAVES downstream slaves, with response timeout, miss handling,
// a local STATUS CSR and a sticky fault interrupt.
// Optional per-slave completion counters: define WB_SLAVE_MUX_STATS_EN.
module wb_slave_mux
  import wb_slave_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
  parameter int unsigned WIN_BITS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [WIN_BITS-1:0]      s_adr_o,
  output logic [31:0]              s_dat_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  output logic                     irq_o
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [WIN_BITS-1:0] adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         timer_q, timer_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                to_q, to_d;
  logic                miss_q, miss_d;
  logic [IDX_W-1:0]    last_to_q, last_to_d;
`ifdef WB_SLAVE_MUX_STATS_EN
  logic [15:0]         cnt_q [NUM_SLAVES];
  logic [15:0]         cnt_d [NUM_SLAVES];
`endif

  logic                dec_hit, dec_csr;
  logic [IDX_W-1:0]    dec_idx;
  logic [WIN_BITS-1:0] csr_off;
  logic [31:0]         csr_rdata;
  logic                ack_sel;
  logic [31:0]         slave_rdata;
  logic                busy;

  wb_slave_mux_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_BASE  (ADDR_BASE),
    .WIN_BITS   (WIN_BITS)
  ) u_decode (
    .adr_i     (wbs_adr_i),
    .hit_o     (dec_hit),
    .csr_hit_o (dec_csr),
    .idx_o     (dec_idx)
  );

  assign busy    = (state_q == BUSY);
  assign csr_off = wbs_adr_i[WIN_BITS-1:0];

  // CSR read mux, evaluated on the live address while accepting in IDLE.
  always_comb begin
    csr_rdata = '0;
    if (csr_off == WIN_BITS'(CSR_STATUS))
      csr_rdata = {25'd0, last_to_q, 2'b00, miss_q, to_q};
`ifdef WB_SLAVE_MUX_STATS_EN
    for (int unsigned k = 0; k < NUM_SLAVES; k++)
      if (csr_off == WIN_BITS'(CSR_STATS_BASE + 4 * k))
        csr_rdata = {16'd0, cnt_q[k]};
`endif
  end

  // Select ack and read data of the latched slave; other acks are ignored.
  always_comb begin
    ack_sel     = 1'b0;
    slave_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++)
      if (idx_q == k[IDX_W-1:0]) begin
        ack_sel     = s_ack_i[k];
        slave_rdata = s_dat_i[32*k +: 32];
      end
  end

  // Next-state, request latching, response capture and flag updates.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    to_d      = to_q;
    miss_d    = miss_q;
    last_to_d = last_to_q;
`ifdef WB_SLAVE_MUX_STATS_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          adr_d   = wbs_adr_i[WIN_BITS-1:0];
          dat_d   = wbs_dat_i;
          idx_d   = dec_idx;
          timer_d = '0;
          if (dec_hit) begin
            state_d = BUSY;
          end else if (dec_csr) begin
            state_d = RESP;
            rdata_d = wbs_we_i ? '0 : csr_rdata;
            if (wbs_we_i && csr_off == WIN_BITS'(CSR_STATUS) && wbs_sel_i[0]) begin
              to_d   = to_q & ~wbs_dat_i[0];
              miss_d = miss_q & ~wbs_dat_i[1];
            end
`ifdef WB_SLAVE_MUX_STATS_EN
            if (wbs_we_i && csr_off == WIN_BITS'(CSR_STATS_CLR))
              cnt_d = '{default: '0};
`endif
          end else begin
            state_d = RESP;
            rdata_d = MISS_DATA;
            miss_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (ack_sel) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : slave_rdata;
`ifdef WB_SLAVE_MUX_STATS_EN
          for (int unsigned k = 0; k < NUM_SLAVES; k++)
            if (idx_q == k[IDX_W-1:0] && cnt_q[k] != 16'hFFFF)
              cnt_d[k] = cnt_q[k] + 16'd1;
`endif
        end else if (timer_q == 16'(TIMEOUT_CYCLES)) begin
          state_d   = RESP;
          rdata_d   = TIMEOUT_DATA;
          to_d      = 1'b1;
          last_to_d = idx_q;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      rdata_q   <= '0;
      to_q      <= 1'b0;
      miss_q    <= 1'b0;
      last_to_q <= '0;
`ifdef WB_SLAVE_MUX_STATS_EN
      cnt_q     <= '{default: '0};
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      to_q      <= to_d;
      miss_q    <= miss_d;
      last_to_q <= last_to_d;
`ifdef WB_SLAVE_MUX_STATS_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Downstream strobes are one-hot and only live in BUSY.
  always_comb begin
    s_stb_o = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++)
      s_stb_o[k] = busy && (idx_q == k[IDX_W-1:0]);
  end

  assign s_cyc_o   = s_stb_o;
  assign s_we_o    = busy & we_q;
  assign s_sel_o   = busy ? sel_q : '0;
  assign s_adr_o   = busy ? adr_q : '0;
  assign s_dat_o   = busy ? dat_q : '0;
  assign wbs_ack_o = (state_q == RESP);
  assign wbs_dat_o = rdata_q;
  assign irq_o     = to_q | miss_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed scoreboard bench for wb_slave_mux (NUM_SLAVES=4, TIMEOUT_CYCLES=8).
module tb_wb_slave_mux;

  localparam int unsigned NS = 4;
  localparam int unsigned WB = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic              s_we_o;
  logic [3:0]        s_sel_o;
  logic [WB-1:0]     s_adr_o;
  logic [31:0]       s_dat_o;
  logic [32*NS-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i;
  logic              irq_o;

  // Slave models
  logic [NS-1:0]     ack_en;
  logic [NS-1:0]     ack_force;
  int unsigned       ack_dly;
  int unsigned       stb_cnt;
  logic [31:0]       slv_data [NS];

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  // Per-transaction observations
  logic          got;
  int            lat;
  logic [31:0]   rd;
  logic [NS-1:0] snap_stb, stb_any;
  logic [WB-1:0] snap_adr;
  logic [31:0]   snap_dat;
  logic          snap_we;
  logic          ack_any;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .NUM_SLAVES     (NS),
    .ADDR_BASE      (32'h3000_0000),
    .WIN_BITS       (WB),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_sel_o    (s_sel_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_dat_i    (s_dat_i),
    .s_ack_i    (s_ack_i),
    .irq_o      (irq_o)
  );

  // Cycles the current downstream strobe has been held.
  always @(posedge clk) begin
    if (|s_stb_o) stb_cnt <= stb_cnt + 1;
    else          stb_cnt <= 0;
  end

  for (genvar k = 0; k < NS; k++) begin : g_slv
    assign s_dat_i[32*k +: 32] = slv_data[k];
    assign s_ack_i[k] = ack_force[k] |
                        (ack_en[k] & s_cyc_o[k] & s_stb_o[k] & (stb_cnt >= ack_dly));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one transaction and wait (bounded) for its upstream ack.
  task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                     input logic [3:0] t_sel);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_dat; sel = t_sel;
    got = 1'b0; lat = 0; rd = '0; stb_any = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        snap_stb = s_stb_o; snap_adr = s_adr_o; snap_dat = s_dat_o; snap_we = s_we_o;
      end
      stb_any |= s_stb_o;
      if (wbs_ack_o) begin got = 1'b1; lat = i; rd = wbs_dat_o; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Pop the scoreboard and compare the response just collected.
  task automatic expect_resp(input string tag, input int exp_lat);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_data"}, rd, e);
    chk({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_ack_once"}, 32'(wbs_ack_o), 32'd0);
    chk({tag, "_hold"}, wbs_dat_o, e);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    ack_en = '0; ack_force = '0; ack_dly = 0;
    for (int k = 0; k < NS; k++) slv_data[k] = 32'h1000_0000 * (k + 1);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ack", 32'(wbs_ack_o), 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_stb", 32'(s_stb_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    rst_n = 1'b1;

    // Read slave 2, ack on first BUSY cycle
    ack_en = 4'b0100; slv_data[2] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    txn(1'b0, 32'h3002_0010, 32'h0, 4'hF);
    chk("rd_s2_stb", 32'(snap_stb), 32'h4);
    chk("rd_s2_adr", 32'(snap_adr), 32'h0010);
    expect_resp("rd_s2", 1);

    // Write slave 0, silent slave: timeout after 9 BUSY cycles
    ack_en = '0;
    exp_q.push_back(32'hDEAD_BEEF);
    txn(1'b1, 32'h3000_0008, 32'hCAFE_0001, 4'h3);
    chk("to_s0_stb", 32'(snap_stb), 32'h1);
    chk("to_s0_we", 32'(snap_we), 1);
    chk("to_s0_wdat", snap_dat, 32'hCAFE_0001);
    expect_resp("to_s0", 9);
    chk("to_s0_irq", 32'(irq_o), 1);
    exp_q.push_back(32'h0000_0001);
    txn(1'b0, 32'h3004_0000, 32'h0, 4'hF);
    expect_resp("status_to", 0);

    // W1C without sel[0] must not clear; with sel[0] it clears
    exp_q.push_back(32'h0);
    txn(1'b1, 32'h3004_0000, 32'h3, 4'hE);
    expect_resp("w1c_nosel", 0);
    chk("w1c_nosel_irq", 32'(irq_o), 1);
    exp_q.push_back(32'h0);
    txn(1'b1, 32'h3004_0000, 32'h1, 4'h1);
    expect_resp("w1c_to", 0);
    chk("w1c_to_irq", 32'(irq_o), 0);

    // Misses: outside region, and unmapped window inside region
    exp_q.push_back(32'hBADA_DD00);
    txn(1'b0, 32'h3100_0000, 32'h0, 4'hF);
    chk("miss_stb", 32'(stb_any), 0);
    expect_resp("miss_out", 0);
    chk("miss_irq", 32'(irq_o), 1);
    exp_q.push_back(32'h0000_0002);
    txn(1'b0, 32'h3004_0000, 32'h0, 4'hF);
    expect_resp("status_miss", 0);
    exp_q.push_back(32'hBADA_DD00);
    txn(1'b1, 32'h3005_0000, 32'h1, 4'hF);
    chk("miss_win5_stb", 32'(stb_any), 0);
    expect_resp("miss_win5", 0);
    exp_q.push_back(32'h0);
    txn(1'b1, 32'h3004_0000, 32'h2, 4'h1);
    expect_resp("w1c_miss", 0);
    chk("w1c_miss_irq", 32'(irq_o), 0);
    exp_q.push_back(32'h0);
    txn(1'b0, 32'h3004_0004, 32'h0, 4'hF);
    expect_resp("csr_other", 0);

    // Ack and timeout in the same cycle: ack wins, no flag
    ack_en = 4'b0010; ack_dly = 8; slv_data[1] = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    txn(1'b0, 32'h3001_0000, 32'h0, 4'hF);
    expect_resp("ack_at_to", 9);
    chk("ack_at_to_irq", 32'(irq_o), 0);

    // Ack one cycle too late on slave 3 while others ack unselected
    ack_en = 4'b1000; ack_dly = 9; ack_force = 4'b0111;
    exp_q.push_back(32'hDEAD_BEEF);
    txn(1'b0, 32'h3003_0004, 32'h0, 4'hF);
    expect_resp("to_s3", 9);
    ack_force = '0; ack_dly = 0;
    exp_q.push_back(32'h0000_0031);
    txn(1'b0, 32'h3004_0000, 32'h0, 4'hF);
    expect_resp("status_s3", 0);

    // Reset asserted during BUSY: everything clears, no ack
    ack_en = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3002_0020; wdat = 32'hA5A5_A5A5; sel = 4'hF;
    @(negedge clk);
    chk("rstb_busy_dat", s_dat_o, 32'hA5A5_A5A5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstb_ack", 32'(wbs_ack_o), 0);
    chk("rstb_dat", wbs_dat_o, 0);
    chk("rstb_strobes", {24'd0, s_cyc_o, s_stb_o}, 0);
    chk("rstb_shared", {11'd0, s_we_o, s_sel_o, s_adr_o} | s_dat_o, 0);
    chk("rstb_irq", 32'(irq_o), 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
    exp_q.push_back(32'h0);
    txn(1'b0, 32'h3004_0000, 32'h0, 4'hF);
    expect_resp("status_rst", 0);

    // Upstream abort during BUSY on slave 1
    ack_en = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0040; sel = 4'hF;
    repeat (2) @(negedge clk);
    chk("abort_busy_stb", 32'(s_stb_o), 32'h2);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_stb_drop", 32'(s_stb_o), 0);
    ack_any = wbs_ack_o;
    repeat (4) begin @(negedge clk); ack_any |= wbs_ack_o; end
    chk("abort_no_ack", 32'(ack_any), 0);
    ack_en = 4'b0010; slv_data[1] = 32'h5555_AAAA;
    exp_q.push_back(32'h5555_AAAA);
    txn(1'b0, 32'h3001_0040, 32'h0, 4'hF);
    expect_resp("after_abort", 1);
    exp_q.push_back(32'h0);
    txn(1'b1, 32'h3001_0044, 32'h7777_0000, 4'hC);
    expect_resp("wr_s1", 1);

`ifdef WB_SLAVE_MUX_STATS_EN
    // 3 acked reads + 1 timeout on slave 3
    ack_en = 4'b1000; slv_data[3] = 32'h3333_0003;
    repeat (3) begin
      exp_q.push_back(32'h3333_0003);
      txn(1'b0, 32'h3003_0000, 32'h0, 4'hF);
      expect_resp("st_rd_s3", 1);
    end
    ack_en = '0;
    exp_q.push_back(32'hDEAD_BEEF);
    txn(1'b0, 32'h3003_0000, 32'h0, 4'hF);
    expect_resp("st_to_s3", 9);
    exp_q.push_back(32'd3);
    txn(1'b0, 32'h3004_001C, 32'h0, 4'hF);
    expect_resp("st_cnt3", 0);
    exp_q.push_back(32'd2);
    txn(1'b0, 32'h3004_0014, 32'h0, 4'hF);
    expect_resp("st_cnt1", 0);
    exp_q.push_back(32'h0);
    txn(1'b1, 32'h3004_000C, 32'h0, 4'h0);
    expect_resp("st_clr", 0);
    exp_q.push_back(32'h0);
    txn(1'b0, 32'h3004_001C, 32'h0, 4'hF);
    expect_resp("st_cnt3_clr", 0);
`else
    exp_q.push_back(32'h0);
    txn(1'b0, 32'h3004_0014, 32'h0, 4'hF);
    expect_resp("nost_cnt1", 0);
    exp_q.push_back(32'h0);
    txn(1'b0, 32'h3004_001C, 32'h0, 4'hF);
    expect_resp("nost_cnt3", 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Parametrised Wishbone slave-side fabric in the user area, between the management SoC Wishbone port and NUM_SLAVES downstream user peripherals.
- Decodes the upstream address into equal windows and forwards one transaction at a time to the selected slave.
- Registers the response, enforces a per-transaction timeout and answers unmapped addresses itself.
- Provides a local status CSR window and a sticky fault interrupt.

Parameters:
- NUM_SLAVES, 4, downstream slave count (1..8).
- ADDR_BASE, 32'h3000_0000, user-area base address; must be aligned to 2^(WIN_BITS+4).
- WIN_BITS, 16, log2 of each slave's byte window.
- TIMEOUT_CYCLES, 255, BUSY cycles allowed before forced response (1..65535).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_n_i  in  1  synchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone controls.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  upstream ack.
- wbs_dat_o  out  32  upstream read data.
- s_cyc_o, s_stb_o  out  NUM_SLAVES  one-hot downstream cyc/stb.
- s_we_o  out  1  shared downstream write enable.
- s_sel_o  out  4  shared downstream byte selects.
- s_adr_o  out  WIN_BITS  window-relative address.
- s_dat_o  out  32  shared downstream write data.
- s_dat_i  in  32*NUM_SLAVES  flattened read data; slave k at bits [32k+31:32k].
- s_ack_i  in  NUM_SLAVES  per-slave ack.
- irq_o  out  1  level interrupt, = timeout_flag | miss_flag.

Behaviour:
- Address map:
  - Slave k window: ADDR_BASE + (k << WIN_BITS).
  - CSR window: ADDR_BASE + (NUM_SLAVES << WIN_BITS).
  - Any other address is a miss.
- Reset: on the first wb_clk_i edge with wb_rst_n_i low, every output goes to 0, the FSM goes to IDLE, and both flags and all counters clear. Reset mid-transaction drops it with no ack.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Waits for wbs_cyc_i & wbs_stb_i, then latches we, sel, adr, dat and the decoded index.
  - Slave hit: go to BUSY.
  - CSR hit or miss: go to RESP.
    - CSR hit: perform the CSR access.
    - Miss: return data 32'hBADA_DD00 and set miss_flag.
- BUSY:
  - Drives s_cyc_o[k] = s_stb_o[k] = 1 with the latched fields; s_adr_o = adr[WIN_BITS-1:0].
  - s_ack_i[k]: capture s_dat_i slice k (reads), drop s_cyc/s_stb in the next state, go to RESP.
  - Timeout: the timer counts from 0; when it reaches TIMEOUT_CYCLES with no ack, return data 32'hDEAD_BEEF, set timeout_flag, record last_to_idx = k, go to RESP.
  - Ack and timeout in the same cycle: ack wins, no flag.
  - Acks on non-selected slaves are ignored.
- RESP:
  - wbs_ack_o = 1 for exactly one cycle, with wbs_dat_o valid (0 for writes), then return to IDLE.
  - wbs_ack_o is 0 in every other state.
  - wbs_dat_o holds its value until the next RESP.
- Upstream abort: wbs_cyc_i low in BUSY aborts the transaction.
  - Downstream strobes deassert next cycle, FSM returns to IDLE, no ack.
- Latency: stb sampled at edge 0; slave acking at first opportunity; wbs_ack_o high after edge 2. Throughput is one transaction per 3 cycles minimum.
- New request: may be accepted in IDLE the cycle after RESP.
- CSR at offset 0x0, STATUS:
  - bit0 timeout_flag, bit1 miss_flag, bits[6:4] last_to_idx.
  - Write-1-to-clear on bits 1:0, honouring wbs_sel_i[0].
  - Set and clear of the same flag in the same cycle: set wins.
- CSR reads of other offsets return 0; CSR writes to other offsets are ignored.

Optional Feature:
- Macro: WB_SLAVE_MUX_STATS_EN.
- Defined:
  - Per-slave 16-bit completed-transaction counters, incremented on the RESP of a slave ack. Timeouts and aborts do not count.
  - Counters saturate at 16'hFFFF.
  - Counter k is readable at CSR offset 0x10 + 4k.
  - Any write to offset 0x0C clears all counters.
- Undefined: no counter logic; those offsets read 0 and writes have no effect.

Decomposition:
- Package wb_slave_mux_pkg holds:
  - FSM state enum.
  - MISS_DATA = 32'hBADA_DD00 and TIMEOUT_DATA = 32'hDEAD_BEEF.
  - CSR offsets STATUS = 0x00, STATS_CLR = 0x0C, STATS_BASE = 0x10.
- Sub-module wb_slave_mux_decode: purely combinational address-to-{hit, csr_hit, index} decoder, parametrised identically.

Test Plan:
- Read slave 2 (adr 0x3002_0010), slave acks on its first BUSY cycle with 0x1234_5678 -> s_adr_o = 0x0010, wbs_ack_o one cycle at edge 2, wbs_dat_o = 0x1234_5678.
- Write slave 0 with a silent slave, TIMEOUT_CYCLES = 8 -> ack with 0xDEAD_BEEF after timeout, STATUS = 0x0000_0001 (last_to_idx 0), irq_o = 1. Write 0x1 to STATUS -> irq_o = 0.
- Read 0x3100_0000 -> no s_stb_o asserted, ack with 0xBADA_DD00, STATUS bit1 = 1.
- Drop wbs_cyc_i during BUSY on slave 1 -> s_stb_o[1] low next cycle, no wbs_ack_o; next transaction completes normally.
- Assert wb_rst_n_i low during BUSY -> all outputs 0 after that edge, flags cleared, no ack.
- With WB_SLAVE_MUX_STATS_EN: 3 acked reads to slave 3 plus 1 timeout -> CSR 0x1C reads 3; write 0x0C -> reads 0.
